// File: rtl/sdram_arb_pkg.sv
// Shared constants and FSM encoding for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W        = 25;
    localparam int DATA_W        = 32;
    localparam int DEF_NUM_PORTS = 4;

    typedef enum logic {
        ARB    = 1'b0,
        SETTLE = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Small synchronous FIFO holding the port index of each outstanding read.
// Push and pop may coincide, including when full.
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // When full, the popped slot is the one being overwritten, so a paired push is safe.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) rd_q <= ptr_inc(rd_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_PORTS requesters.
// Define SDRAM_ARB_PRIO0_EN to give port 0 absolute priority over the round-robin ports.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int TAG_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        p_req,
    input  logic [NUM_PORTS-1:0]        p_rw,
    input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
    output logic [NUM_PORTS-1:0]        p_ack,
    output logic [DATA_W-1:0]           p_rdata,
    output logic [NUM_PORTS-1:0]        p_rvalid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_rw,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_in_valid,
    input  logic                        mem_busy,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_out_valid,
    output logic                        tag_err
);
    localparam int PORT_W = idx_w(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 in_valid_q, in_valid_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
    logic                 terr_q, terr_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 found, prio_hit;
    logic [PORT_W-1:0]    win;
    logic [PORT_W:0]      cand;
    logic                 push, pop;
    logic [PORT_W-1:0]    fifo_head;
    logic                 fifo_full, fifo_empty;

    sdram_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (PORT_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (win),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Reads need a free tag slot; writes are always eligible.
    always_comb begin
        elig     = p_req & (p_rw | {NUM_PORTS{!fifo_full}});
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        prio_hit = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = {1'b0, rr_q} + (PORT_W+1)'(k);
            if (cand >= (PORT_W+1)'(NUM_PORTS)) cand = cand - (PORT_W+1)'(NUM_PORTS);
            if (!found && elig[cand[PORT_W-1:0]]) begin
                found = 1'b1;
                win   = cand[PORT_W-1:0];
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (elig[0]) begin
            found    = 1'b1;
            win      = '0;
            prio_hit = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        in_valid_d = 1'b0;
        ack_d      = '0;
        push       = 1'b0;
        case (state_q)
            ARB: begin
                if (!mem_busy && found) begin
                    addr_d     = p_addr[win*ADDR_W +: ADDR_W];
                    rw_d       = p_rw[win];
                    wdata_d    = p_wdata[win*DATA_W +: DATA_W];
                    in_valid_d = 1'b1;
                    ack_d[win] = 1'b1;
                    push       = !p_rw[win];
                    if (!prio_hit)
                        rr_d = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
                    state_d = SETTLE;
                end
            end
            // Controller busy lags its accept by a cycle; hold off one cycle.
            SETTLE:  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = '0;
        terr_d   = terr_q;
        pop      = 1'b0;
        if (mem_out_valid) begin
            rdata_d = mem_rdata;
            if (fifo_empty) begin
                terr_d = 1'b1;
            end else begin
                pop                 = 1'b1;
                rvalid_d[fifo_head] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_q       <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            in_valid_q <= 1'b0;
            ack_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            in_valid_q <= in_valid_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            terr_q     <= terr_d;
        end
    end

    assign p_ack        = ack_q;
    assign p_rdata      = rdata_q;
    assign p_rvalid     = rvalid_q;
    assign mem_addr     = addr_q;
    assign mem_rw       = rw_q;
    assign mem_wdata    = wdata_q;
    assign mem_in_valid = in_valid_q;
    assign tag_err      = terr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_sdram_port_arbiter;
    localparam int NP = 4;
    localparam int TD = 2;
    localparam int AW = 25;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    p_req = '0;
    logic [NP-1:0]    p_rw = '0;
    logic [NP*AW-1:0] p_addr = '0;
    logic [NP*DW-1:0] p_wdata = '0;
    logic             mem_busy = 1'b0;
    logic             mem_out_valid = 1'b0;
    logic [DW-1:0]    mem_rdata = '0;

    logic [NP-1:0]    p_ack, p_rvalid;
    logic [DW-1:0]    p_rdata, mem_wdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_rw, mem_in_valid, tag_err;

    // model state and expected outputs
    logic [NP-1:0] e_ack = '0, e_rv = '0;
    logic [DW-1:0] e_rdata = '0, e_wdata = '0;
    logic [AW-1:0] e_addr = '0;
    logic          e_rw = 1'b0, e_inv = 1'b0, e_terr = 1'b0;
    int            tags[$];
    int            rr = 0, cyc = 0, last_g = -10;

    int n_cmp = 0, n_bad = 0;
    int rdq_n = 0;
    int seq_port[$];
    int seq_t[$];
    int cnt;

    sdram_port_arbiter #(.NUM_PORTS(NP), .TAG_DEPTH(TD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .p_req         (p_req),
        .p_rw          (p_rw),
        .p_addr        (p_addr),
        .p_wdata       (p_wdata),
        .p_ack         (p_ack),
        .p_rdata       (p_rdata),
        .p_rvalid      (p_rvalid),
        .mem_addr      (mem_addr),
        .mem_rw        (mem_rw),
        .mem_wdata     (mem_wdata),
        .mem_in_valid  (mem_in_valid),
        .mem_busy      (mem_busy),
        .mem_rdata     (mem_rdata),
        .mem_out_valid (mem_out_valid),
        .tag_err       (tag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        tags.delete();
        rr = 0;
        last_g = cyc - 10;
        e_ack = '0; e_rv = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
        e_rw = 1'b0; e_inv = 1'b0; e_terr = 1'b0;
    endtask

    // One clock edge of the arbiter, from the rules: round-robin from rr, reads need a
    // free tag, grants at least two edges apart, returns go to the oldest tag.
    task automatic model_step();
        int occ, win, h;
        bit prio;
        occ   = tags.size();
        e_ack = '0; e_rv = '0; e_inv = 1'b0;
        if (mem_out_valid) begin
            e_rdata = mem_rdata;
            if (occ == 0) e_terr = 1'b1;
            else begin
                h = tags.pop_front();
                e_rv[h] = 1'b1;
            end
        end
        win = -1;
        prio = 1'b0;
        if (!mem_busy && (cyc - last_g >= 2)) begin
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (rr + k) % NP;
                if (win < 0 && p_req[i] && (p_rw[i] || occ < TD)) win = i;
            end
`ifdef SDRAM_ARB_PRIO0_EN
            if (p_req[0] && (p_rw[0] || occ < TD)) begin
                win = 0;
                prio = 1'b1;
            end
`endif
        end
        if (win >= 0) begin
            e_ack[win] = 1'b1;
            e_inv      = 1'b1;
            e_addr     = p_addr[win*AW +: AW];
            e_rw       = p_rw[win];
            e_wdata    = p_wdata[win*DW +: DW];
            if (!p_rw[win]) tags.push_back(win);
            if (!prio) rr = (win + 1) % NP;
            last_g = cyc;
        end
        cyc++;
    endtask

    // Single compare process: step the model on each edge, check outputs on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            n_cmp++;
            if ({p_ack, p_rvalid, p_rdata, mem_addr, mem_rw, mem_wdata, mem_in_valid, tag_err} !==
                {e_ack, e_rv, e_rdata, e_addr, e_rw, e_wdata, e_inv, e_terr}) begin
                n_bad++;
                $display("FAIL cycle_cmp t=%0t ack=%h/%h rv=%h/%h rdata=%h/%h addr=%h/%h rw=%b/%b wdata=%h/%h inv=%b/%b terr=%b/%b (got/want)",
                         $time, p_ack, e_ack, p_rvalid, e_rv, p_rdata, e_rdata, mem_addr, e_addr,
                         mem_rw, e_rw, mem_wdata, e_wdata, mem_in_valid, e_inv, tag_err, e_terr);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        p_req = '0; p_rw = '0; mem_busy = 1'b0; mem_out_valid = 1'b0; rdq_n = 0;
        #1;
        chk("reset_ack", 128'(p_ack), 128'd0);
        chk("reset_inv", 128'(mem_in_valid), 128'd0);
        chk("reset_rvalid", 128'(p_rvalid), 128'd0);
        chk("reset_terr", 128'(tag_err), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int port, input int budget, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!p_ack[port] && n < budget);
        chk(nm, 128'(p_ack[port]), 128'd1);
        p_req[port] = 1'b0;
    endtask

    task automatic ret(input logic [DW-1:0] d, input logic [NP-1:0] want_rv, input string nm);
        mem_rdata = d;
        mem_out_valid = 1'b1;
        @(negedge clk);
        mem_out_valid = 1'b0;
        chk({nm, "_rvalid"}, 128'(p_rvalid), 128'(want_rv));
        chk({nm, "_rdata"}, 128'(p_rdata), 128'(d));
    endtask

    initial begin
        model_reset();

        // single read from port 2
        do_reset();
        p_req[2] = 1'b1; p_rw[2] = 1'b0; p_addr[2*AW +: AW] = 25'h0000100;
        @(negedge clk);
        chk("t1_ack", 128'(p_ack), 128'b0100);
        chk("t1_inv", 128'(mem_in_valid), 128'd1);
        chk("t1_addr", 128'(mem_addr), 128'h100);
        chk("t1_rw", 128'(mem_rw), 128'd0);
        p_req[2] = 1'b0;
        @(negedge clk);
        chk("t1_inv_pulse", 128'(mem_in_valid), 128'd0);
        chk("t1_ack_pulse", 128'(p_ack), 128'd0);
        ret(32'hDEADBEEF, 4'b0100, "t1_ret");
        @(negedge clk);
        chk("t1_rvalid_pulse", 128'(p_rvalid), 128'd0);

        // continuous writes
        do_reset();
        for (int i = 0; i < NP; i++) begin
            p_wdata[i*DW +: DW] = 32'h1111_1111 * i;
            p_addr[i*AW +: AW]  = AW'(i);
        end
        p_rw = '1;
        seq_port.delete(); seq_t.delete();
`ifdef SDRAM_ARB_PRIO0_EN
        p_req = 4'b0011;
`else
        p_req = '1;
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++)
                if (p_ack[i]) begin
                    seq_port.push_back(i);
                    seq_t.push_back(c);
                    chk("t2_wdata", 128'(mem_wdata), 128'(32'h1111_1111 * i));
                end
        end
        chk("t2_count", 128'(seq_port.size()), 128'd5);
        for (int j = 0; j < 5 && j < seq_port.size(); j++) begin
`ifdef SDRAM_ARB_PRIO0_EN
            chk("t2_prio_port", 128'(seq_port[j]), 128'd0);
`else
            chk("t2_port", 128'(seq_port[j]), 128'(j % NP));
`endif
            chk("t2_spacing", 128'(seq_t[j]), 128'(2 * j));
        end
`ifdef SDRAM_ARB_PRIO0_EN
        p_req[0] = 1'b0;
        wait_ack(1, 4, "t2_prio_port1");
`endif
        p_req = '0;

        // tag FIFO full: reads blocked, writes still served
        do_reset();
        p_rw = '0;
        p_addr[1*AW +: AW] = 25'h11; p_req[1] = 1'b1;
        wait_ack(1, 4, "t3_ack1");
        p_addr[3*AW +: AW] = 25'h33; p_req[3] = 1'b1;
        wait_ack(3, 4, "t3_ack3");
        p_req[0] = 1'b1; p_rw[2] = 1'b1; p_req[2] = 1'b1;
        wait_ack(2, 4, "t3_ack2");
        chk("t3_ack2_only", 128'(p_ack), 128'b0100);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (p_ack[0]) cnt++;
        end
        chk("t3_p0_blocked", 128'(cnt), 128'd0);
        ret(32'hAAAA0001, 4'b0010, "t3_ret1");
        wait_ack(0, 4, "t3_ack0");
        ret(32'hAAAA0003, 4'b1000, "t3_ret3");
        ret(32'hAAAA0000, 4'b0001, "t3_ret0");

        // busy holds off grants
        do_reset();
        mem_busy = 1'b1; p_rw[1] = 1'b1; p_req[1] = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (p_ack != '0 || mem_in_valid) cnt++;
        end
        chk("t4_busy_hold", 128'(cnt), 128'd0);
        mem_busy = 1'b0;
        @(negedge clk);
        chk("t4_ack_after_busy", 128'(p_ack), 128'b0010);
        p_req[1] = 1'b0;

        // tag_err and async reset mid-transfer
        do_reset();
        mem_rdata = 32'h12345678; mem_out_valid = 1'b1;
        @(negedge clk);
        mem_out_valid = 1'b0;
        chk("t5_terr", 128'(tag_err), 128'd1);
        chk("t5_no_rvalid", 128'(p_rvalid), 128'd0);
        repeat (5) @(negedge clk);
        chk("t5_terr_sticky", 128'(tag_err), 128'd1);
        p_rw[1] = 1'b0; p_addr[1*AW +: AW] = 25'h1ABCDEF; p_req[1] = 1'b1;
        wait_ack(1, 4, "t5_ack");
        chk("t5_inv_before_rst", 128'(mem_in_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_inv", 128'(mem_in_valid), 128'd0);
        chk("t5_rst_ack", 128'(p_ack), 128'd0);
        chk("t5_rst_addr", 128'(mem_addr), 128'd0);
        chk("t5_rst_terr", 128'(tag_err), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_out_valid = 1'b1;
        @(negedge clk);
        mem_out_valid = 1'b0;
        chk("t5_orphan_terr", 128'(tag_err), 128'd1);
        chk("t5_orphan_rv", 128'(p_rvalid), 128'd0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++)
                if (p_ack[i]) p_req[i] = 1'b0;
            for (int i = 0; i < NP; i++)
                if (!p_req[i] && $urandom_range(3) == 0) begin
                    p_req[i] = 1'b1;
                    p_rw[i]  = 1'($urandom_range(1));
                    p_addr[i*AW +: AW]  = AW'($urandom);
                    p_wdata[i*DW +: DW] = $urandom;
                end
            mem_busy = ($urandom_range(2) == 0);
            mem_out_valid = 1'b0;
            if (rdq_n > 0 && $urandom_range(2) == 0) begin
                mem_out_valid = 1'b1;
                mem_rdata = $urandom;
                rdq_n--;
            end
            if (mem_in_valid && !mem_rw) rdq_n++;
        end
        @(negedge clk);
        p_req = '0; mem_out_valid = 1'b0; mem_busy = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller user interface between NUM_PORTS requesters (video fetch, CPU, DMA, ...).
- Round-robin arbitration issues one-cycle request pulses to the controller, honouring its busy flag.
- Each read is tagged with the issuing port so the read data returns to the correct requester.
- Sits between the requesters and the SDRAM controller, in the controller's clock domain.

Parameters:
- NUM_PORTS, 4, number of requesting ports (2..8).
- PORT_W, 2, index width, equal to clog2(NUM_PORTS); derived, not overridden.
- TAG_DEPTH, 2, outstanding-read tag FIFO depth. Covers the controller's 1-deep queue plus the operation in flight.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  NUM_PORTS  per-port request, held until p_ack.
- p_rw  in  NUM_PORTS  per-port direction, 1 = write, 0 = read.
- p_addr  in  NUM_PORTS*25  per-port word address, packed with port 0 in the LSBs.
- p_wdata  in  NUM_PORTS*32  per-port write data, packed.
- p_ack  out  NUM_PORTS  one-cycle pulse: request taken.
- p_rdata  out  32  read data, broadcast to all ports.
- p_rvalid  out  NUM_PORTS  one-cycle pulse on the port owning p_rdata.
- mem_addr  out  25  to controller addr.
- mem_rw  out  1  to controller rw.
- mem_wdata  out  32  to controller data_in.
- mem_in_valid  out  1  to controller in_valid.
- mem_busy  in  1  from controller busy.
- mem_rdata  in  32  from controller data_out.
- mem_out_valid  in  1  from controller out_valid.
- tag_err  out  1  sticky: mem_out_valid arrived with the tag FIFO empty.

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; tag FIFO empty; FSM in ARB.
- Reset asserted mid-operation aborts immediately. Outstanding reads are dropped; their later mem_out_valid sets tag_err.
- All outputs are registered.
- FSM has two states, ARB and SETTLE.
- ARB: when mem_busy=0, at least one p_req is high, and the selected request is allowed by the tag FIFO check:
  - register mem_addr/mem_rw/mem_wdata from the winner;
  - drive mem_in_valid=1 and p_ack[winner]=1 for exactly one cycle;
  - if it is a read, push the winner index into the tag FIFO;
  - go to SETTLE.
- SETTLE lasts one cycle. mem_in_valid=0, no arbitration, then return to ARB. This is needed because the controller's busy flag asserts one cycle after it accepts a request.
- Round-robin search starts at the rr pointer. After a grant, rr = winner+1, wrapping from NUM_PORTS-1 to 0.
- Reads are not issued while the tag FIFO is full. The search skips read requesters; write requesters remain eligible.
- A port dropping p_req before its ack is a protocol violation; the arbiter simply re-evaluates the next cycle.
- Read return:
  - on mem_out_valid, pop the FIFO head h;
  - p_rdata <= mem_rdata and p_rvalid[h] <= 1, one cycle after mem_out_valid;
  - the controller returns reads in order, so FIFO order matches return order.
- Simultaneous push and pop in the same cycle is legal, including when the FIFO is full. Occupancy is unchanged.
- mem_out_valid with the FIFO empty sets tag_err; p_rvalid stays 0. tag_err clears only on reset.
- Latency: request-to-ack is 1 cycle minimum (p_req seen in ARB, ack next edge). The issue rate is at most one request per 2 cycles.

Optional Feature:
- Macro: SDRAM_ARB_PRIO0_EN.
- Defined: port 0 has fixed absolute priority. Whenever p_req[0] is eligible it wins, and the rr pointer is not advanced. Remaining ports share round-robin among themselves. Intended for the display refill port.
- Undefined: pure round-robin across all ports.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - constants ADDR_W=25, DATA_W=32;
  - FSM state encoding ARB/SETTLE;
  - default NUM_PORTS.
- One sub-module, sdram_arb_tag_fifo: a TAG_DEPTH-deep, PORT_W-wide synchronous FIFO with push/pop/full/empty, simultaneous push+pop allowed, async active-low reset.

Test Plan:
- Single port 2 reads addr 25'h0000100, mem_busy model 0 → p_ack[2] one pulse; mem_in_valid one pulse with addr 25'h0000100, rw=0. Controller returns 32'hDEADBEEF → p_rvalid[2] pulses once 1 cycle later with p_rdata=32'hDEADBEEF.
- All 4 ports request writes continuously, busy always 0 → grants in order 0,1,2,3,0, spaced exactly 2 cycles apart. Each p_ack aligns with its mem_wdata (port n data = 32'h1111_1111*n).
- Ports 1 and 3 each issue reads, memory delays both returns, port 0 then requests a read and port 2 a write → port 2's write is granted and port 0 is blocked until the first return. Returns route to ports 1 then 3.
- mem_busy held high for 20 cycles with p_req[1]=1 → no mem_in_valid and no ack. Busy falls → ack within 1 cycle.
- mem_out_valid pulsed with no outstanding read → tag_err=1 and stays 1. Asserting rst_n=0 mid-transfer clears all outputs and the FIFO asynchronously.
- With SDRAM_ARB_PRIO0_EN, ports 0 and 1 requesting continuously → port 0 wins every grant. Port 0 idle → port 1 granted.
